// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
// Build option: define ARB_TIMEOUT_EN to enable the bus-timeout counter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

  localparam logic RST_ENABLE    = 1'b1;
  localparam int   TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Busy-cycle counter for the arbiter; flags expiry in the cycle that reaches the limit.
// Instantiated only when ARB_TIMEOUT_EN is defined.
module arb_timeout_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int CNT_W = TIMEOUT_CNT_W,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clear) begin
      cnt <= '0;
    end else if (enable && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the stalled cycles already seen, so this cycle is number cnt+1
  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between OpenMIPS IF and MEM with req/ack handshakes.
// Build option: ARB_TIMEOUT_EN adds a busy timeout that aborts with bus_err.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_ack,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_sel,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_sel,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stallreq_if,
  output logic                stallreq_mem,
  output logic                bus_err
);

  localparam int SEL_W = DATA_W / 8;

  state_t              state, state_n;
  grant_t              last_grant, last_n;
  logic                mem_req_n, mem_we_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n;
  logic [SEL_W-1:0]    mem_sel_n;
  logic [DATA_W-1:0]   inst_rdata_n, data_rdata_n;
  logic                inst_ack_n, data_ack_n, bus_err_n;
  logic                grant_now, timeout_hit;

`ifdef ARB_TIMEOUT_EN
  arb_timeout_cnt #(
    .CNT_W (TIMEOUT_CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant_now),
    .enable  (state == ST_BUSY && !mem_ack),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_n       = last_grant;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    mem_sel_n    = mem_sel;
    inst_rdata_n = inst_rdata;
    data_rdata_n = data_rdata;
    inst_ack_n   = 1'b0;
    data_ack_n   = 1'b0;
    bus_err_n    = 1'b0;
    grant_now    = 1'b0;
    case (state)
      ST_IDLE: begin
        // Data wins a tie unless it was served last, so neither side starves
        if (data_req && (!inst_req || last_grant == GRANT_INST)) begin
          grant_now   = 1'b1;
          last_n      = GRANT_DATA;
          mem_req_n   = 1'b1;
          mem_we_n    = data_we;
          mem_addr_n  = data_addr;
          mem_wdata_n = data_wdata;
          mem_sel_n   = data_sel;
          state_n     = ST_BUSY;
        end else if (inst_req) begin
          grant_now   = 1'b1;
          last_n      = GRANT_INST;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b0;
          mem_addr_n  = inst_addr;
          mem_wdata_n = '0;
          mem_sel_n   = '1;
          state_n     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A real completion takes precedence over a timeout in the same cycle
        if (mem_ack || timeout_hit) begin
          mem_req_n = 1'b0;
          state_n   = ST_DONE;
          bus_err_n = !mem_ack;
          if (last_grant == GRANT_DATA) begin
            data_rdata_n = mem_ack ? mem_rdata : '0;
            data_ack_n   = 1'b1;
          end else begin
            inst_rdata_n = mem_ack ? mem_rdata : '0;
            inst_ack_n   = 1'b1;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      last_grant <= GRANT_INST;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_sel    <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      last_grant <= last_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_sel    <= mem_sel_n;
      inst_rdata <= inst_rdata_n;
      data_rdata <= data_rdata_n;
      inst_ack   <= inst_ack_n;
      data_ack   <= data_ack_n;
      bus_err    <= bus_err_n;
    end
  end

  assign stallreq_if  = inst_req & ~inst_ack;
  assign stallreq_mem = data_req & ~data_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, queued expectations,
// and an independent negedge monitor. Timeout case runs when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } op_t;

  logic        clk, rst;
  logic        inst_req, inst_ack, data_req, data_we, data_ack;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  logic [3:0]  data_sel, mem_sel;
  logic        mem_req, mem_we, mem_ack, stallreq_if, stallreq_mem, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;
  int ack_delay = 0;
  logic no_ack = 1'b0;
  logic spurious = 1'b0;
  int buserr_seen = 0;
  int buserr_exp = 0;

  op_t         pend_data[$];
  logic [31:0] pend_inst[$];
  op_t         exp_grant[$];
  logic [31:0] exp_inst_rd[$];
  logic [31:0] exp_data_rd[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ack(inst_ack),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_sel(data_sel), .data_rdata(data_rdata), .data_ack(data_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .bus_err(bus_err)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_model(logic [31:0] a);
    case (a)
      32'h10:  return 32'h3401_1100;
      32'h14:  return 32'h1414_0014;
      32'h18:  return 32'h1818_0018;
      32'h1C:  return 32'h1C1C_001C;
      32'h40:  return 32'hCAFE_0040;
      32'h44:  return 32'h4444_0044;
      32'h48:  return 32'h4848_0048;
      32'h80:  return 32'h8080_8080;
      32'h100: return 32'h0BAD_0100;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic op_t mk(logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] s);
    op_t o;
    o.we = we; o.addr = a; o.wdata = wd; o.sel = s;
    return o;
  endfunction

  // Requesters: drop on ack, then raise the next queued access if any
  task automatic cycle();
    op_t o;
    @(posedge clk); #1;
    if (inst_ack) inst_req = 1'b0;
    if (data_ack) data_req = 1'b0;
    if (!inst_req && pend_inst.size() > 0) begin
      inst_req  = 1'b1;
      inst_addr = pend_inst.pop_front();
    end
    if (!data_req && pend_data.size() > 0) begin
      o = pend_data.pop_front();
      data_req = 1'b1; data_we = o.we; data_addr = o.addr;
      data_wdata = o.wdata; data_sel = o.sel;
    end
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((pend_inst.size() > 0 || pend_data.size() > 0 || inst_req || data_req) && n < 300) begin
      cycle();
      n++;
    end
    if (n >= 300) check({name, "_timeout"}, 32'(n), 32'd0);
    cycle();
    cycle();
  endtask

  // Memory responder
  initial begin
    int wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_ack = 1'b0;
      if (spurious) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_2222;
      end else if (rst || !mem_req || no_ack) begin
        wcnt = 0;
      end else if (wcnt == ack_delay) begin
        mem_ack = 1'b1;
        mem_rdata = mem_model(mem_addr);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic prev_req = 1'b0;
    logic prev_done = 1'b0;
    op_t  held = '0;
    op_t  e;
    forever begin
      @(negedge clk);
      check("ack_latency", 32'(inst_ack | data_ack), 32'(prev_done | bus_err));
      check("stallreq_if", 32'(stallreq_if), 32'(inst_req & ~inst_ack));
      check("stallreq_mem", 32'(stallreq_mem), 32'(data_req & ~data_ack));
      if (bus_err) buserr_seen++;
      if (mem_req && !prev_req) begin
        if (exp_grant.size() == 0) begin
          check("unexpected_grant", mem_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_grant.pop_front();
          check("grant_we", 32'(mem_we), 32'(e.we));
          check("grant_addr", mem_addr, e.addr);
          check("grant_wdata", mem_wdata, e.wdata);
          check("grant_sel", 32'(mem_sel), 32'(e.sel));
          held = mk(mem_we, mem_addr, mem_wdata, mem_sel);
        end
      end else if (mem_req) begin
        check("busy_stable", 32'(held != mk(mem_we, mem_addr, mem_wdata, mem_sel)), 32'd0);
      end
      if (inst_ack) begin
        if (exp_inst_rd.size() == 0) check("unexpected_inst_ack", inst_rdata, 32'hFFFF_FFFF);
        else check("inst_rdata", inst_rdata, exp_inst_rd.pop_front());
      end
      if (data_ack) begin
        if (exp_data_rd.size() == 0) check("unexpected_data_ack", data_rdata, 32'hFFFF_FFFF);
        else check("data_rdata", data_rdata, exp_data_rd.pop_front());
      end
      prev_done = mem_req && mem_ack && !rst;
      prev_req  = mem_req;
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_sel = '0;

    // Reset with both requesters pending: data write first, then instruction fetch
    pend_data.push_back(mk(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF));
    pend_inst.push_back(32'h100);
    exp_grant.push_back(mk(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF));
    exp_grant.push_back(mk(1'b0, 32'h100, 32'h0, 4'hF));
    exp_data_rd.push_back(32'hCAFE_0040);
    exp_inst_rd.push_back(32'h0BAD_0100);
    repeat (18) cycle();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_sel", 32'(mem_sel), 32'd0);
    check("rst_acks", 32'({inst_ack, data_ack}), 32'd0);
    check("rst_inst_rdata", inst_rdata, 32'd0);
    check("rst_data_rdata", data_rdata, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    #14 rst = 1'b0;
    cycle();
    check("first_grant_req", 32'(mem_req), 32'd1);
    check("first_grant_we", 32'(mem_we), 32'd1);
    drain("simul");

    // Lone fetch, memory answers one cycle after the request
    ack_delay = 1;
    pend_inst.push_back(32'h10);
    exp_grant.push_back(mk(1'b0, 32'h10, 32'h0, 4'hF));
    exp_inst_rd.push_back(32'h3401_1100);
    cycle();
    cycle();
    check("stall_if_waiting", 32'(stallreq_if), 32'd1);
    drain("lone_inst");

    // Both held continuously: grants alternate D, I, D, I
    ack_delay = 0;
    pend_data.push_back(mk(1'b0, 32'h44, 32'h0, 4'h3));
    pend_data.push_back(mk(1'b0, 32'h48, 32'h0, 4'hF));
    pend_inst.push_back(32'h14);
    pend_inst.push_back(32'h18);
    exp_grant.push_back(mk(1'b0, 32'h44, 32'h0, 4'h3));
    exp_grant.push_back(mk(1'b0, 32'h14, 32'h0, 4'hF));
    exp_grant.push_back(mk(1'b0, 32'h48, 32'h0, 4'hF));
    exp_grant.push_back(mk(1'b0, 32'h18, 32'h0, 4'hF));
    exp_data_rd.push_back(32'h4444_0044);
    exp_data_rd.push_back(32'h4848_0048);
    exp_inst_rd.push_back(32'h1414_0014);
    exp_inst_rd.push_back(32'h1818_0018);
    drain("alternate");

    // Slow memory: five wait cycles
    ack_delay = 5;
    pend_data.push_back(mk(1'b0, 32'h80, 32'h0, 4'hF));
    exp_grant.push_back(mk(1'b0, 32'h80, 32'h0, 4'hF));
    exp_data_rd.push_back(32'h8080_8080);
    drain("slow_mem");

    // Stray mem_ack while idle must not produce a completion
    spurious = 1'b1;
    cycle();
    spurious = 1'b0;
    cycle();
    check("spurious_ack_a", 32'({inst_ack, data_ack}), 32'd0);
    cycle();
    check("spurious_ack_b", 32'({inst_ack, data_ack}), 32'd0);

    // Reset in the middle of a long access
    ack_delay = 20;
    pend_inst.push_back(32'h20);
    exp_grant.push_back(mk(1'b0, 32'h20, 32'h0, 4'hF));
    n = 0;
    do begin cycle(); n++; end while (!mem_req && n < 20);
    check("abort_granted", 32'(mem_req), 32'd1);
    cycle();
    cycle();
    rst = 1'b1;
    inst_req = 1'b0;
    cycle();
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_no_ack", 32'(inst_ack), 32'd0);
    rst = 1'b0;
    cycle();
    check("abort_no_ack_later", 32'(inst_ack), 32'd0);
    ack_delay = 0;
    pend_data.push_back(mk(1'b0, 32'h1C, 32'h0, 4'hF));
    exp_grant.push_back(mk(1'b0, 32'h1C, 32'h0, 4'hF));
    exp_data_rd.push_back(32'h1C1C_001C);
    drain("after_abort");

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: abort on the edge after the fourth busy cycle
    no_ack = 1'b1;
    pend_inst.push_back(32'h30);
    exp_grant.push_back(mk(1'b0, 32'h30, 32'h0, 4'hF));
    exp_inst_rd.push_back(32'h0);
    buserr_exp = 1;
    n = 0;
    do begin cycle(); n++; end while (!mem_req && n < 20);
    repeat (3) cycle();
    check("to_early_ack", 32'(inst_ack), 32'd0);
    check("to_early_err", 32'(bus_err), 32'd0);
    cycle();
    check("to_ack", 32'(inst_ack), 32'd1);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_rdata", inst_rdata, 32'd0);
    no_ack = 1'b0;
    drain("timeout");
`endif

    check("bus_err_pulses", 32'(buserr_seen), 32'(buserr_exp));
    check("grants_left", 32'(exp_grant.size()), 32'd0);
    check("inst_left", 32'(exp_inst_rd.size()), 32'd0);
    check("data_left", 32'(exp_data_rd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port of the minimal SOPC between the instruction-fetch stage (IF) and the load/store stage (MEM) of the OpenMIPS core.
- Sequences each access as a req/ack transaction and raises stall requests toward the pipeline ctrl block while a requester waits.
- Sits between the core and the RAM/ROM bus in openmips_min_sopc.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT_CYCLES, 255, busy cycles without mem_ack before abort. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- inst_req  in  1  IF read request; held high until inst_ack.
- inst_addr  in  ADDR_W  IF address; stable while inst_req is high.
- inst_rdata  out  DATA_W  fetched word; valid in the inst_ack cycle.
- inst_ack  out  1  one-cycle completion pulse to IF.
- data_req  in  1  MEM request; held high until data_ack.
- data_we  in  1  1 = write, 0 = read.
- data_addr  in  ADDR_W  MEM address.
- data_wdata  in  DATA_W  write data.
- data_sel  in  DATA_W/8  byte enables.
- data_rdata  out  DATA_W  load data; valid in the data_ack cycle.
- data_ack  out  1  one-cycle completion pulse to MEM.
- mem_req  out  1  downstream request; registered.
- mem_we  out  1  downstream write enable; registered.
- mem_addr  out  ADDR_W  downstream address; registered.
- mem_wdata  out  DATA_W  downstream write data; registered.
- mem_sel  out  DATA_W/8  downstream byte enables; registered.
- mem_rdata  in  DATA_W  downstream read data; sampled with mem_ack.
- mem_ack  in  1  downstream completion; may arrive any cycle while mem_req is high.
- stallreq_if  out  1  stall request for IF.
- stallreq_mem  out  1  stall request for MEM.
- bus_err  out  1  one-cycle timeout pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset values: state=IDLE, all mem_* = 0, inst_ack = data_ack = 0, inst_rdata = data_rdata = 0, last_grant = INST, bus_err = 0.
- FSM IDLE:
  - Only data_req high: grant DATA.
  - Only inst_req high: grant INST.
  - Both high: grant DATA unless last_grant == DATA, in which case grant INST. This alternation prevents starvation.
  - A grant latches the requester's fields into mem_*, sets mem_req = 1 and last_grant, and moves to BUSY.
  - An INST grant drives mem_we = 0 and mem_sel = all ones.
- FSM BUSY:
  - mem_req held high and fields held stable.
  - When mem_ack = 1: latch mem_rdata into the granted requester's rdata, clear mem_req, pulse the granted ack next cycle, and go to DONE.
  - mem_rdata for writes is don't-care; rdata is updated anyway.
- FSM DONE: exactly one cycle with the ack high; no new grant is made here, so the requester can drop req; then go to IDLE.
- Latency: req sampled in cycle N → mem_req at N+1 → earliest mem_ack at N+1 → ack at N+2 → IDLE at N+3. Back-to-back accesses by alternating requesters take 3 cycles each with zero-wait memory.
- mem_ack outside BUSY: ignored.
- stallreq_if = inst_req & ~inst_ack; stallreq_mem = data_req & ~data_ack. Both are combinational from registered acks.
- Requester drops req while BUSY: protocol violation; the transaction still completes and the ack still pulses.
- rst mid-transaction: returns to IDLE next edge with mem_req = 0. The downstream memory shares rst and must abandon the access.
- No address or data arithmetic; fields pass through unmodified.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - An 8..16-bit counter clears on grant and increments on each BUSY cycle without mem_ack.
  - On reaching TIMEOUT_CYCLES: clear mem_req, go to DONE, pulse the granted ack with rdata = 0, and pulse bus_err for 1 cycle (same cycle as the ack).
  - mem_ack arriving on the same cycle as the timeout wins: normal completion, no bus_err.
- Without the macro: BUSY waits indefinitely; bus_err is constant 0; no counter is synthesised.

Decomposition:
- Shared defines: FSM encodings (IDLE/BUSY/DONE), GRANT_INST/GRANT_DATA, `RstEnable`/`RstDisable`, bus width macros.
- Optional sub-module arb_timeout_cnt (clear/enable/expired) under ARB_TIMEOUT_EN; everything else stays in one module.

Test Plan:
- Reset held 195 ns with both reqs high → all outputs 0; first grant at the first edge after reset release.
- Only inst_req, addr 0x0000_0010, mem_ack one cycle after mem_req with rdata 0x3401_1100 → inst_ack pulses 1 cycle with inst_rdata = 0x3401_1100; stallreq_if high until that ack.
- Simultaneous inst_req and data_req (write 0xDEAD_BEEF, addr 0x40, sel 4'b1111) → data served first, then inst. Repeat with both held → grants alternate D, I, D, I.
- mem_ack delayed 5 cycles → mem_* stable for all 5 cycles and the ack arrives exactly 1 cycle after mem_ack. A spurious mem_ack in IDLE causes no ack.
- rst asserted while BUSY → mem_req = 0 next edge, no ack, state IDLE.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4, mem_ack never asserted → ack with rdata = 0 and bus_err pulse on the 4th busy cycle's following edge.
